// File: rtl/fpu_dot_pkg.sv
// fpu_dot_pkg: shared state encoding, FPU opcodes and constants for fpu_dot_seq
package fpu_dot_pkg;
  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_MUL_ISSUE,
    S_MUL_WAIT,
    S_ADD_ISSUE,
    S_ADD_WAIT,
    S_DONE
  } state_e;
  localparam logic [2:0]  OP_ADD  = 3'b000;
  localparam logic [2:0]  OP_SUB  = 3'b001;
  localparam logic [2:0]  OP_MUL  = 3'b010;
  localparam logic [31:0] FP_ZERO = 32'h0;
endpackage

// File: rtl/fpu_dot_seq.sv
// fpu_dot_seq: sequential dot product on an external FPU (mul then add per pair)
// Optional FPU_DOT_SEQ_BIAS_EN: accumulator starts from bias_i instead of +0.0
module fpu_dot_seq
  import fpu_dot_pkg::*;
#(
  parameter int LEN_W = 8
) (
  input  logic             clk_i,
  input  logic             rstn_i,
  input  logic             start_i,
  input  logic [LEN_W-1:0] len_i,
  input  logic [31:0]      bias_i,
  input  logic [31:0]      a_i,
  input  logic [31:0]      b_i,
  input  logic             ab_valid_i,
  output logic             ab_ready_o,
  output logic [31:0]      fpu_opa_o,
  output logic [31:0]      fpu_opb_o,
  output logic [2:0]       fpu_op_o,
  output logic [1:0]       fpu_rmode_o,
  output logic             fpu_start_o,
  input  logic [31:0]      fpu_result_i,
  input  logic             fpu_ready_i,
  input  logic             fpu_ovf_i,
  input  logic             fpu_nan_i,
  output logic [31:0]      res_o,
  output logic             res_valid_o,
  input  logic             res_ready_i,
  output logic             busy_o,
  output logic             err_o
);
  state_e           state_q, state_d;
  logic [LEN_W-1:0] len_q, len_d, count_q, count_d, count_inc;
  logic [31:0]      a_q, a_d, b_q, b_d, prod_q, prod_d, acc_q, acc_d, init;
  logic             err_q, err_d, mul_ph, add_ph;
`ifdef FPU_DOT_SEQ_BIAS_EN
  assign init = bias_i;
`else
  logic unused_bias;
  assign unused_bias = ^bias_i;
  assign init = FP_ZERO;
`endif
  assign mul_ph      = state_q inside {S_MUL_ISSUE, S_MUL_WAIT};
  assign add_ph      = state_q inside {S_ADD_ISSUE, S_ADD_WAIT};
  // operands come straight from registers, so they stay stable across the whole wait
  assign fpu_opa_o   = mul_ph ? a_q : add_ph ? acc_q : FP_ZERO;
  assign fpu_opb_o   = mul_ph ? b_q : add_ph ? prod_q : FP_ZERO;
  assign fpu_op_o    = mul_ph ? OP_MUL : OP_ADD;
  assign fpu_rmode_o = 2'b00;
  assign fpu_start_o = state_q inside {S_MUL_ISSUE, S_ADD_ISSUE};
  assign ab_ready_o  = state_q == S_FETCH;
  assign busy_o      = state_q != S_IDLE;
  assign res_valid_o = state_q == S_DONE;
  assign res_o       = res_valid_o ? acc_q : FP_ZERO;
  assign err_o       = err_q;
  assign count_inc   = count_q + 1'b1;
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    count_d = count_q;
    a_d     = a_q;
    b_d     = b_q;
    prod_d  = prod_q;
    acc_d   = acc_q;
    err_d   = err_q;
    case (state_q)
      S_IDLE: if (start_i) begin
        len_d   = len_i;
        acc_d   = init;
        count_d = '0;
        err_d   = 1'b0;
        state_d = len_i == '0 ? S_DONE : S_FETCH;
      end
      S_FETCH: if (ab_valid_i) begin
        a_d     = a_i;
        b_d     = b_i;
        state_d = S_MUL_ISSUE;
      end
      S_MUL_ISSUE: state_d = S_MUL_WAIT;
      S_MUL_WAIT: if (fpu_ready_i) begin
        prod_d  = fpu_result_i;
        err_d   = err_q | fpu_ovf_i | fpu_nan_i;
        state_d = S_ADD_ISSUE;
      end
      S_ADD_ISSUE: state_d = S_ADD_WAIT;
      S_ADD_WAIT: if (fpu_ready_i) begin
        acc_d   = fpu_result_i;
        count_d = count_inc;
        err_d   = err_q | fpu_ovf_i | fpu_nan_i;
        state_d = count_inc == len_q ? S_DONE : S_FETCH;
      end
      S_DONE: if (res_ready_i) state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q <= S_IDLE;
      len_q   <= '0;
      count_q <= '0;
      a_q     <= FP_ZERO;
      b_q     <= FP_ZERO;
      prod_q  <= FP_ZERO;
      acc_q   <= FP_ZERO;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      len_q   <= len_d;
      count_q <= count_d;
      a_q     <= a_d;
      b_q     <= b_d;
      prod_q  <= prod_d;
      acc_q   <= acc_d;
      err_q   <= err_d;
    end
  end
endmodule

// File: doc/fpu_dot_seq.md
FPU_DOT_SEQ -- requirements
Module: fpu_dot_seq

Interface
REQ-001 SHALL have parameter LEN_W, default 8, meaning the width of the vector-length field (maximum length 2^LEN_W-1).
REQ-002 SHALL have port clk_i  input  1  clock, all state updates on the rising edge.
REQ-003 SHALL have port rstn_i  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port start_i  input  1  starts a job; sampled only in IDLE.
REQ-005 SHALL have port len_i  input  LEN_W  number of operand pairs, latched together with start_i.
REQ-006 SHALL have port bias_i  input  32  IEEE-754 single initial accumulator, latched with start_i (used only with the macro in REQ-029).
REQ-007 SHALL have ports a_i and b_i  input  32 each  operand pair; ab_valid_i  input  1; ab_ready_o  output  1 (valid/ready handshake).
REQ-008 SHALL have ports fpu_opa_o and fpu_opb_o  output  32 each; fpu_op_o  output  3; fpu_rmode_o  output  2 (fixed 2'b00); fpu_start_o  output  1 (one-cycle pulse).
REQ-009 SHALL have ports fpu_result_i  input  32; fpu_ready_i  input  1; fpu_ovf_i and fpu_nan_i  input  1 each (the FPU overflow_o and qnan_o/snan_o OR).
REQ-010 SHALL have ports res_o  output  32; res_valid_o  output  1; res_ready_i  input  1; busy_o  output  1; err_o  output  1.

Function
REQ-011 SHALL compute acc = init + sum(a[k]*b[k]), k=0..len-1, using the external FPU sequentially: multiply (op 3'b010) then add (op 3'b000, opa=acc, opb=product) per pair.
REQ-012 SHALL implement the states IDLE, FETCH, MUL_ISSUE, MUL_WAIT, ADD_ISSUE, ADD_WAIT, DONE.
REQ-013 IDLE: on start_i=1, latch len_i, set acc=init, clear count and err, go to FETCH, or go to DONE when len_i=0.
REQ-014 FETCH: drive ab_ready_o=1; on ab_valid_i & ab_ready_o, capture a_i/b_i into registers and go to MUL_ISSUE.
REQ-015 MUL_ISSUE/ADD_ISSUE: assert fpu_start_o for exactly one cycle with stable operands and op, then go to the matching WAIT state.
REQ-016 Operands and op SHALL be held stable from the ISSUE cycle until fpu_ready_i is seen.
REQ-017 MUL_WAIT: on fpu_ready_i, register product=fpu_result_i and go to ADD_ISSUE. ADD_WAIT: on fpu_ready_i, register acc=fpu_result_i and increment count; go to DONE if count+1==len, else FETCH.
REQ-018 The add's fpu_ready_i SHALL be the one that follows its own start; a stray fpu_ready_i in any non-WAIT state SHALL be ignored.
REQ-019 On every accepted fpu_ready_i, err SHALL be set (sticky) if fpu_ovf_i or fpu_nan_i is 1; the job SHALL still complete.
REQ-020 DONE: res_valid_o=1, res_o=acc, err_o=err, all held stable; on res_ready_i=1 go to IDLE.
REQ-021 A job SHALL take exactly 1 cycle for FETCH (with input valid), plus 2 cycles ISSUE, plus the FPU latency for each op, per pair.
REQ-022 len=0 SHALL present res_o=init in DONE on the cycle after start.
REQ-023 start_i outside IDLE SHALL be ignored; busy_o=1 in every state except IDLE.
REQ-024 ab_ready_o SHALL be 1 only in FETCH; ab_valid_i low in FETCH SHALL stall indefinitely without side effects.
REQ-025 count SHALL be LEN_W bits; len=2^LEN_W-1 SHALL complete without wrap.

Reset
REQ-026 On rstn_i=0, at any time including mid-job, the FSM SHALL enter IDLE and discard the job.
REQ-027 The following outputs SHALL be 0 while in reset and after it: ab_ready_o, fpu_start_o, res_valid_o, busy_o, err_o. res_o, fpu_opa_o, fpu_opb_o, acc and count SHALL be 32'h0; fpu_op_o SHALL be 3'b000.
REQ-028 The FPU SHALL share rstn_i, so no in-flight FPU result survives reset.

Configuration
REQ-029 Macro FPU_DOT_SEQ_BIAS_EN: when defined, init=bias_i latched at start; when undefined, init=32'h00000000 (+0.0), bias_i is unused and the bias register is not built.

Structure
REQ-030 A shared package fpu_dot_pkg SHALL hold the state encoding, the FPU opcodes (OP_ADD=3'b000, OP_SUB=3'b001, OP_MUL=3'b010) and the constant FP_ZERO=32'h0.
REQ-031 No sub-module is required; the FPU is instantiated by the parent, not inside this block.

Verification
REQ-032 len=1, a=0x40000000, b=0x40400000, with a behavioural FPU model -> res_o=0x40C00000 (6.0), err_o=0, exactly one mul start and one add start.
REQ-033 len=3, a={1.0,2.0,3.0}, b={1.0,1.0,1.0}, ab_valid_i toggled randomly -> res_o=0x40C00000, 3 handshakes, no lost or duplicated pairs.
REQ-034 len=0, start -> res_valid_o=1 on the next cycle with res_o=0x00000000, fpu_start_o never asserted.
REQ-035 Product 0x7F000000*0x7F000000 with the FPU reporting fpu_ovf_i=1 -> err_o=1 in DONE; res_ready_i held low for 10 cycles -> res_o and res_valid_o stable throughout.
REQ-036 rstn_i asserted in ADD_WAIT -> all outputs at reset values immediately; a new len=1 job (2.0*3.0) after reset -> 0x40C00000.
REQ-037 With FPU_DOT_SEQ_BIAS_EN, bias=0x3F800000, len=1, 2.0*3.0 -> res_o=0x40E00000 (7.0).
